sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
//
// PURPOSE
//   Shares port 1 of the unified byte-addressed SRAM between the instruction-fetch unit
//   and the load/store unit. Each requester gets a valid/ready request channel and a
//   registered 1-cycle response.
//   - Load/store has priority.
//   - A starvation counter guarantees fetch progress.
//   Sits between the core pipeline and sram, replacing direct port wiring.
//
// PARAMETERS
//   ADDR_WIDTH    32  byte-address width of all address buses
//   DATA_WIDTH    32  word width; byte-enable width = DATA_WIDTH/8
//   STARVE_LIMIT  4   max consecutive LS grants while fetch waits; 1..15
//
// PORTS
//   clk              in   1             clock
//   rst              in   1             synchronous reset, active-high
//   if_req_valid     in   1             fetch request present
//   if_req_ready     out  1             fetch request accepted this cycle
//   if_addr          in   ADDR_WIDTH    fetch word address
//   if_rsp_valid     out  1             fetch response valid (1-cycle pulse)
//   if_rsp_data      out  DATA_WIDTH    fetched instruction word
//   ls_req_valid     in   1             load/store request present
//   ls_req_ready     out  1             load/store request accepted this cycle
//   ls_we            in   1             1 = store, 0 = load
//   ls_addr          in   ADDR_WIDTH    load/store byte address
//   ls_wdata         in   DATA_WIDTH    store data, little-endian lanes
//   ls_be            in   DATA_WIDTH/8  store byte enables
//   ls_rsp_valid     out  1             load data valid / store ack (1-cycle pulse)
//   ls_rsp_data      out  DATA_WIDTH    load data; 0 for store ack
//   mem_write_en     out  1             to sram port1_write_en
//   mem_address      out  ADDR_WIDTH    to sram port1_address
//   mem_write_data   out  DATA_WIDTH    to sram port1_write_data
//   mem_byte_enable  out  DATA_WIDTH/8  to sram port1_byte_enable
//   mem_read_data    in   DATA_WIDTH    from sram port1_read_data (combinational)
//
// BEHAVIOUR
// - Reset values:
//   - *_rsp_valid=0, *_rsp_data=0.
//   - starve_cnt=0.
//   - Grant state = IDLE.
//   - Ready outputs are combinational and are 0 while rst is high.
// - Grant (combinational, cycle N):
//   - ls_req_ready=1 if ls_req_valid and NOT force_if.
//   - if_req_ready=1 if if_req_valid and (NOT ls_req_valid or force_if).
//   - force_if = (starve_cnt == STARVE_LIMIT) and if_req_valid.
//   - At most one ready high per cycle.
//   - Handshake completes on valid&ready.
//   - Requesters hold address and data stable until ready.
// - Memory drive in cycle N:
//   - LS grant: mem_address=ls_addr; mem_write_en=ls_we; mem_write_data=ls_wdata;
//     mem_byte_enable = ls_be if ls_we, else 0.
//   - IF grant or no grant: mem_address=if_addr; mem_write_en=0; mem_byte_enable=0.
// - Response in cycle N+1:
//   - The granted side's rsp_valid pulses for exactly 1 cycle.
//   - rsp_data is mem_read_data registered at the end of cycle N.
//   - A store returns an ack with ls_rsp_data=0.
//   - Non-granted rsp_valid=0; its rsp_data holds its previous value.
//   - No response back-pressure: requesters must sink responses.
//   - Throughput: 1 transaction/cycle.
// - Grant FSM: registered state {IDLE, GNT_IF, GNT_LS}.
//   - Next state = the side granted this cycle, else IDLE.
//   - The state selects which rsp_valid fires in N+1.
// - starve_cnt, 4-bit saturating:
//   - LS grant while if_req_valid=1: +1.
//   - IF grant, or if_req_valid=0: cleared to 0.
//   - Never exceeds STARVE_LIMIT.
// - Reset mid-operation: rsp_valid=0 on the cycle after rst; the in-flight response is
//   dropped and no memory write is issued while rst=1.
//
// TESTING
//   1. IF only, if_addr=0x10, mem word 0x00000013 -> if_req_ready in N;
//      if_rsp_valid=1, if_rsp_data=0x00000013 in N+1.
//   2. LS store addr=0x20, wdata=0xDEADBEEF, be=0b0011, then load 0x20 (prior word 0) ->
//      ls_rsp_data=0x0000BEEF.
//   3. IF and LS both valid for 1 cycle -> LS granted; IF granted next cycle;
//      responses in order LS then IF.
//   4. IF and LS continuously valid, STARVE_LIMIT=4 -> grant pattern LS,LS,LS,LS,IF
//      repeating; starve_cnt never >4.
//   5. rst asserted the cycle after an LS load grant -> ls_rsp_valid stays 0;
//      no writes; all outputs at reset values.
//   6. Store with be=0b1111 -> mem_write_en=1 only in the grant cycle;
//      ls_rsp_valid=1, ls_rsp_data=0 in N+1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares SRAM port 1 between instruction fetch and load/store.
// Load/store wins by default. A saturating starvation counter forces a fetch grant
// once load/store has won STARVE_LIMIT times in a row while fetch was waiting.
// Each grant returns a registered response one cycle later.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_LS = 2'd2
  } gnt_state_e;

  gnt_state_e            state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0] if_rsp_data_q, if_rsp_data_d;
  logic [DATA_WIDTH-1:0] ls_rsp_data_q, ls_rsp_data_d;

  logic force_if;
  logic ls_gnt;
  logic if_gnt;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    force_if = (starve_cnt_q == LIMIT) && if_req_valid;
    ls_gnt   = !rst && ls_req_valid && !force_if;
    if_gnt   = !rst && if_req_valid && (!ls_req_valid || force_if);
  end

  assign ls_req_ready = ls_gnt;
  assign if_req_ready = if_gnt;

  // SRAM port drive: load/store owns the port only on its grant; writes need a store grant.
  always_comb begin
    mem_address     = if_addr;
    mem_write_en    = 1'b0;
    mem_write_data  = '0;
    mem_byte_enable = '0;
    if (ls_gnt) begin
      mem_address     = ls_addr;
      mem_write_en    = ls_we;
      mem_write_data  = ls_wdata;
      mem_byte_enable = ls_we ? ls_be : '0;
    end
  end

  // Next grant state, starvation count and captured response data.
  always_comb begin
    state_d       = IDLE;
    starve_cnt_d  = starve_cnt_q;
    if_rsp_data_d = if_rsp_data_q;
    ls_rsp_data_d = ls_rsp_data_q;

    if (ls_gnt) begin
      state_d       = GNT_LS;
      ls_rsp_data_d = ls_we ? '0 : mem_read_data;
    end else if (if_gnt) begin
      state_d       = GNT_IF;
      if_rsp_data_d = mem_read_data;
    end

    if (if_gnt || !if_req_valid) begin
      starve_cnt_d = 4'd0;
    end else if (ls_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= 4'd0;
      if_rsp_data_q <= '0;
      ls_rsp_data_q <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      if_rsp_data_q <= if_rsp_data_d;
      ls_rsp_data_q <= ls_rsp_data_d;
    end
  end

  // Responses are masked during reset so an in-flight response is dropped immediately.
  assign if_rsp_valid = !rst && (state_q == GNT_IF);
  assign ls_rsp_valid = !rst && (state_q == GNT_LS);
  assign if_rsp_data  = rst ? '0 : if_rsp_data_q;
  assign ls_rsp_data  = rst ? '0 : ls_rsp_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a driver issues directed and random
// requests, a reference model predicts grants and responses, a monitor checks them.
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_be = '0;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;

  sram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behaviour seen by the DUT, and the model's own view of memory.
  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  assign mem_read_data = sram[mem_address[9:2]];

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t if_q[$];
  exp_t ls_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Pending requests held by the requesters until granted.
  bit          p_if = 0, p_ls = 0;
  logic [31:0] p_if_addr, p_ls_addr, p_ls_wdata;
  bit          p_ls_we;
  logic [3:0]  p_ls_be;
  bit          refill_both = 0;
  int          ls_wins = 0;  // LS grants in a row while fetch has been waiting

  function automatic logic [31:0] rand_addr();
    return {22'b0, 8'($urandom_range(0, 31)), 2'b00};
  endfunction

  task automatic set_if(input logic [31:0] a);
    p_if = 1; p_if_addr = a;
  endtask

  task automatic set_ls(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    p_ls = 1; p_ls_we = we; p_ls_addr = a; p_ls_wdata = d; p_ls_be = be;
  endtask

  // One clock cycle: drive, predict at negedge, check port-level outputs, update model.
  task automatic step(input bit r);
    bit force_if, g_ls, g_if;
    logic [31:0] exp_addr;
    exp_t e;
    rst          = r;
    if_req_valid = p_if;
    if_addr      = p_if ? p_if_addr : $urandom();
    ls_req_valid = p_ls;
    ls_we        = p_ls ? p_ls_we : 1'($urandom());
    ls_addr      = p_ls ? p_ls_addr : $urandom();
    ls_wdata     = p_ls ? p_ls_wdata : $urandom();
    ls_be        = p_ls ? p_ls_be : 4'($urandom());
    @(negedge clk);
    if (r) begin
      check("if_req_ready_rst", if_req_ready, 0);
      check("ls_req_ready_rst", ls_req_ready, 0);
      check("mem_write_en_rst", mem_write_en, 0);
      if_q.delete();
      ls_q.delete();
      ls_wins = 0;
    end else begin
      force_if = p_if && (ls_wins >= LIMIT);
      g_ls = p_ls && !force_if;
      g_if = p_if && !g_ls;
      check("ls_req_ready", ls_req_ready, g_ls);
      check("if_req_ready", if_req_ready, g_if);
      check("mem_write_en", mem_write_en, g_ls && p_ls_we);
      exp_addr = g_ls ? p_ls_addr : if_addr;
      check("mem_address", mem_address, exp_addr);
      check("mem_byte_enable", mem_byte_enable, (g_ls && p_ls_we) ? p_ls_be : 4'b0);
      if (g_ls && p_ls_we) check("mem_write_data", mem_write_data, p_ls_wdata);
      if (g_ls) begin
        e.due  = cyc + 1;
        e.data = p_ls_we ? 32'h0 : ref_mem[p_ls_addr[9:2]];
        ls_q.push_back(e);
        if (p_ls_we)
          for (int b = 0; b < 4; b++)
            if (p_ls_be[b]) ref_mem[p_ls_addr[9:2]][8*b +: 8] = p_ls_wdata[8*b +: 8];
        ls_wins = p_if ? ((ls_wins < LIMIT) ? ls_wins + 1 : ls_wins) : 0;
        p_ls = 0;
      end else begin
        ls_wins = 0;
      end
      if (g_if) begin
        e.due  = cyc + 1;
        e.data = ref_mem[p_if_addr[9:2]];
        if_q.push_back(e);
        p_if = 0;
      end
    end
    if (mem_write_en)
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) sram[mem_address[9:2]][8*b +: 8] = mem_write_data[8*b +: 8];
    if (refill_both) begin
      if (!p_if) set_if(rand_addr());
      if (!p_ls) set_ls(1'($urandom()), rand_addr(), $urandom(), 4'($urandom()));
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected response whenever one is due and checks data hold otherwise.
  logic [31:0] if_last = '0, ls_last = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("if_rsp_valid_rst", if_rsp_valid, 0);
      check("ls_rsp_valid_rst", ls_rsp_valid, 0);
      check("if_rsp_data_rst", if_rsp_data, 0);
      check("ls_rsp_data_rst", ls_rsp_data, 0);
      if_last = '0;
      ls_last = '0;
    end else begin
      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        e = if_q.pop_front();
        check("if_rsp_valid", if_rsp_valid, 1);
        check("if_rsp_data", if_rsp_data, e.data);
        if_last = e.data;
      end else begin
        check("if_rsp_valid_idle", if_rsp_valid, 0);
        check("if_rsp_data_hold", if_rsp_data, if_last);
      end
      if (ls_q.size() > 0 && ls_q[0].due == cyc) begin
        e = ls_q.pop_front();
        check("ls_rsp_valid", ls_rsp_valid, 1);
        check("ls_rsp_data", ls_rsp_data, e.data);
        ls_last = e.data;
      end else begin
        check("ls_rsp_valid_idle", ls_rsp_valid, 0);
        check("ls_rsp_data_hold", ls_rsp_data, ls_last);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = $urandom();
      ref_mem[i] = sram[i];
    end
    sram[4] = 32'h0000_0013; ref_mem[4] = 32'h0000_0013;
    sram[8] = 32'h0;         ref_mem[8] = 32'h0;

    repeat (3) step(1);
    step(0);

    // Fetch alone.
    set_if(32'h10);
    step(0);
    step(0);

    // Partial store then load of the same word.
    set_ls(1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    step(0);
    set_ls(0, 32'h20, 32'h0, 4'b0);
    step(0);
    step(0);

    // Simultaneous requests: LS first, then IF.
    set_if(32'h10);
    set_ls(0, 32'h20, 32'h0, 4'b0);
    step(0);
    step(0);
    step(0);

    // Both requesters always busy: starvation limit sets the grant rhythm.
    set_if(rand_addr());
    set_ls(0, rand_addr(), 32'h0, 4'b0);
    refill_both = 1;
    repeat (25) step(0);
    refill_both = 0;
    p_if = 0;
    p_ls = 0;
    step(0);
    step(0);

    // Reset right after a load grant, with a store pending during reset.
    set_ls(0, 32'h20, 32'h0, 4'b0);
    step(0);
    set_ls(1, 32'h24, 32'h1234_5678, 4'b1111);
    step(1);
    step(1);
    step(0);
    step(0);

    // Full-word store.
    set_ls(1, 32'h28, 32'hCAFE_F00D, 4'b1111);
    step(0);
    step(0);
    set_ls(0, 32'h28, 32'h0, 4'b0);
    step(0);
    step(0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if (!p_if && $urandom_range(0, 99) < 60) set_if(rand_addr());
      if (!p_ls && $urandom_range(0, 99) < 50)
        set_ls(1'($urandom()), rand_addr(), $urandom(), 4'($urandom()));
      step($urandom_range(0, 199) == 0);
    end
    p_if = 0;
    p_ls = 0;
    repeat (3) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
